if_id_reg: RTL
==============

IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC and instruction.
REQ-002 SHALL have parameter NOP_INST, default 32'h00000013, bubble instruction (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pc_in  input  XLEN  PC of fetched instruction (from IF PC register).
REQ-006 SHALL have port inst_in  input  XLEN  instruction word from instruction memory.
REQ-007 SHALL have port valid_in  input  1  pc_in/inst_in carry a real instruction.
REQ-008 SHALL have port ready_out  output  1  stage can accept this cycle; drives IF enable.
REQ-009 SHALL have port stall  input  1  hazard unit: ID must hold current instruction.
REQ-010 SHALL have port flush  input  1  taken branch/jump (PCSrc): discard held instruction.
REQ-011 SHALL have ports pc_out, inst_out  output  XLEN  instruction presented to ID.
REQ-012 SHALL have port pc4_out  output  XLEN  pc_out + 4, modulo 2^XLEN.
REQ-013 SHALL have port valid_out  output  1  pc_out/inst_out are a real instruction.

Function
REQ-014 Accept SHALL occur when valid_in && ready_out at a rising edge.
REQ-015 Priority SHALL be rst > flush > stall > accept > idle.
REQ-016 Flush SHALL, next cycle, set valid_out=0 and inst_out=NOP_INST, and discard any accept in the same cycle.
REQ-017 Stall (no flush) SHALL hold pc_out, inst_out, pc4_out and valid_out unchanged.
REQ-018 Accept without stall/flush SHALL load pc_in/inst_in, set valid_out=1, and set pc4_out=pc_in+4; latency 1 cycle.
REQ-019 No accept, no stall, no flush SHALL set valid_out=0 and inst_out=NOP_INST; pc_out holds.
REQ-020 pc4_out SHALL be registered with pc_out; 0xFFFFFFFC+4 wraps to 0x00000000.
REQ-021 Without skid (see Configuration), ready_out SHALL equal !stall combinationally, regardless of flush.

Reset
REQ-022 While rst is high at a rising edge: pc_out=0, pc4_out=4, inst_out=NOP_INST, valid_out=0, skid empty.
REQ-023 ready_out SHALL be 0 while rst is high, and SHALL follow the normal rules from the first cycle after rst falls.
REQ-024 Reset asserted mid-stall or with skid full SHALL discard all held instructions.

Configuration
REQ-025 Macro IF_ID_SKID_EN SHALL, when defined, add a one-entry skid buffer and make ready_out a registered output equal to "skid empty".
REQ-026 With IF_ID_SKID_EN: accept while stall=1 SHALL write the skid; when stall falls, the main register SHALL load from the skid before any new input, and the skid SHALL empty.
REQ-027 With IF_ID_SKID_EN: flush SHALL also empty the skid; ready_out SHALL be 1 the cycle after the flush.
REQ-028 Without IF_ID_SKID_EN: no skid storage SHALL exist, and REQ-021 applies.

Structure
REQ-029 XLEN default, NOP_INST and the pipeline valid/bubble conventions SHALL live in the shared package pipeline_pkg, used by all stage registers.
REQ-030 The skid SHALL be a separate sub-module if_id_skid, instantiated only under IF_ID_SKID_EN.

Verification
REQ-031 Reset: rst=1 for 2 cycles -> valid_out=0, inst_out=0x00000013, pc_out=0, pc4_out=4, ready_out=0; ready_out=1 the cycle after rst falls.
REQ-032 Stream: pc_in 0x0,0x4,0x8 with inst 0x00500093, 0x00A00113, 0x002081B3 and valid_in=1 -> same values on outputs 1 cycle later, each with valid_out=1 and pc4_out=pc+4.
REQ-033 Stall: stall=1 for 3 cycles while holding pc 0x4 -> outputs frozen; ready_out=0 (no skid); next instruction appears 1 cycle after stall falls.
REQ-034 Flush+stall: flush=1 and stall=1 together with pc 0x8 held -> next cycle valid_out=0 and inst_out=0x00000013.
REQ-035 Wrap: accept pc_in=0xFFFFFFFC -> pc4_out=0x00000000.
REQ-036 Skid (IF_ID_SKID_EN): stall rises while accepting pc 0x10 -> skid holds 0x10 and ready_out=0; stall falls -> pc_out=0x10 next cycle; flush with skid full -> skid empty and ready_out=1 next cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared definitions for the pipeline stage registers:
//                default datapath width, the bubble instruction and the
//                valid/bubble encoding used on every stage boundary.
//  Revision    : 1.0  - initial release
// ============================================================================
package pipeline_pkg;

    // Default datapath width for PC and instruction words.
    localparam int unsigned c_XLEN = 32;

    // Bubble instruction injected on flush or idle: addi x0, x0, 0.
    localparam logic [31:0] c_NOP_INST = 32'h0000_0013;

    // A stage slot either carries a real instruction or a bubble.
    localparam logic c_SLOT_VALID  = 1'b1;
    localparam logic c_SLOT_BUBBLE = 1'b0;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/if_id_skid.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_skid
//  Description : One-entry skid buffer for the IF/ID boundary. Captures an
//                instruction that was accepted while ID was stalled so the
//                front end does not have to replay it.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                clear         - flush: drop the held entry
//                wr_en         - capture pc_in/inst_in
//                rd_en         - entry consumed by the main register
//                pc_in/inst_in - instruction to capture
//                full          - entry holds a real instruction
//                pc_out/inst_out - held instruction
//  Revision    : 1.0  - initial release
// ============================================================================
module if_id_skid
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN = c_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] inst_in,
    output logic            full,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] inst_out
);

    logic            r_full;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= c_SLOT_BUBBLE;
            r_pc   <= '0;
            r_inst <= '0;
        end else if (clear) begin
            r_full <= c_SLOT_BUBBLE;
        end else if (wr_en) begin
            r_full <= c_SLOT_VALID;
            r_pc   <= pc_in;
            r_inst <= inst_in;
        end else if (rd_en) begin
            r_full <= c_SLOT_BUBBLE;
        end
    end

    assign full     = r_full;
    assign pc_out   = r_pc;
    assign inst_out = r_inst;

endmodule : if_id_skid
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register with stall, flush and bubble
//                insertion. pc4_out is registered alongside pc_out.
//                Optional one-entry skid buffer enabled by the macro
//                IF_ID_SKID_EN; when undefined, ready_out is !stall.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                pc_in, inst_in      - fetched instruction from IF
//                valid_in            - pc_in/inst_in are real
//                ready_out           - stage can accept (drives IF enable)
//                stall               - hazard unit: hold ID instruction
//                flush               - taken branch/jump: discard
//                pc_out, inst_out    - instruction presented to ID
//                pc4_out             - pc_out + 4 (wrapping)
//                valid_out           - pc_out/inst_out are real
//  Revision    : 1.0  - initial release
// ============================================================================
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter int unsigned     XLEN     = c_XLEN,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(c_NOP_INST)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] inst_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] pc4_out,
    output logic            valid_out
);

    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;
    logic [XLEN-1:0] r_inst;
    logic            r_valid;

    logic            w_accept;

    assign w_accept = valid_in && ready_out;

`ifdef IF_ID_SKID_EN
    logic            w_skid_full;
    logic            w_skid_wr;
    logic            w_skid_rd;
    logic [XLEN-1:0] w_skid_pc;
    logic [XLEN-1:0] w_skid_inst;

    // An instruction accepted while ID is stalled parks in the skid; it is
    // drained into the main register as soon as the stall lifts. Flush wins.
    assign w_skid_wr = w_accept && stall && !flush;
    assign w_skid_rd = w_skid_full && !stall && !flush;

    if_id_skid #(
        .XLEN (XLEN)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .wr_en    (w_skid_wr),
        .rd_en    (w_skid_rd),
        .pc_in    (pc_in),
        .inst_in  (inst_in),
        .full     (w_skid_full),
        .pc_out   (w_skid_pc),
        .inst_out (w_skid_inst)
    );

    // Ready is the registered skid-empty flag, held low while in reset.
    assign ready_out = !rst && !w_skid_full;
`else
    assign ready_out = !rst && !stall;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_pc4   <= c_PC_STEP;
            r_inst  <= NOP_INST;
            r_valid <= c_SLOT_BUBBLE;
        end else if (flush) begin
            // pc_out is left as-is; only the instruction becomes a bubble.
            r_inst  <= NOP_INST;
            r_valid <= c_SLOT_BUBBLE;
        end else if (stall) begin
            r_pc    <= r_pc;
            r_pc4   <= r_pc4;
            r_inst  <= r_inst;
            r_valid <= r_valid;
`ifdef IF_ID_SKID_EN
        end else if (w_skid_full) begin
            // Parked instruction goes ahead of anything new from IF.
            r_pc    <= w_skid_pc;
            r_pc4   <= w_skid_pc + c_PC_STEP;
            r_inst  <= w_skid_inst;
            r_valid <= c_SLOT_VALID;
`endif
        end else if (w_accept) begin
            r_pc    <= pc_in;
            r_pc4   <= pc_in + c_PC_STEP;
            r_inst  <= inst_in;
            r_valid <= c_SLOT_VALID;
        end else begin
            r_inst  <= NOP_INST;
            r_valid <= c_SLOT_BUBBLE;
        end
    end

    assign pc_out    = r_pc;
    assign pc4_out   = r_pc4;
    assign inst_out  = r_inst;
    assign valid_out = r_valid;

endmodule : if_id_reg
`default_nettype wire
